usb_tx_line_encoder: RTL and testbench
======================================

// Module: usb_tx_line_encoder
// PURPOSE
//  Parametrised USB transmit line encoder. Packet bytes enter through a valid/ready stream and are
//  buffered in a small FIFO. The block drives d_plus/d_minus with SYNC, NRZI-encoded bit-stuffed data
//  (LSB first) and EOP. It sits between the packet-assembly logic and the USB pad driver.
//  Its predecessor drove one fixed byte; this block adds:
//  - byte streaming with FIFO buffering;
//  - clock-rate and speed modes;
//  - bit stuffing, EOP, underrun abort.
// PARAMETERS
//  CLKS_PER_BIT  8  clk cycles per USB bit time; legal range >=2
//  FIFO_DEPTH    4  byte FIFO entries; power of 2, >=2
//  LOW_SPEED     0  0: J = (dp=1, dm=0) full speed; 1: J = (dp=0, dm=1) low speed
// PORTS
//  clk          in   1  system clock
//  rst          in   1  synchronous reset, active-high
//  tx_start     in   1  request packet start; sampled only in IDLE
//  tx_data      in   8  byte to transmit
//  tx_valid     in   1  tx_data/tx_last valid
//  tx_last      in   1  marks final byte of packet
//  tx_ready     out  1  FIFO can accept (= !fifo_full)
//  d_plus       out  1  USB D+ line
//  d_minus      out  1  USB D- line
//  tx_busy      out  1  high from accepted tx_start until EOP complete
//  tx_done      out  1  1-cycle pulse at end of EOP
//  tx_underrun  out  1  1-cycle pulse when FIFO empties mid-packet
// BEHAVIOUR
//  Reset values
//  - FIFO flushed; state IDLE; lines at J; tx_busy=0, tx_done=0, tx_underrun=0; tx_ready=1.
//  - rst mid-packet: lines at J on the next edge; no tx_done.
//  FIFO push and start
//  - Push on tx_valid && tx_ready. Push is legal in any state, so bytes may be preloaded before tx_start.
//  - tx_start while busy is ignored.
//  Bit timing
//  - bit_cnt counts 0..CLKS_PER_BIT-1 and is cleared on an accepted tx_start.
//  - Lines update only at bit boundaries. The first K appears on the edge after tx_start is accepted.
//  States: IDLE -> SYNC -> DATA -> EOP -> IDLE
//  - IDLE: lines J. Accepted tx_start -> SYNC; tx_busy=1.
//  - SYNC: 8 bits 00000001 LSB first (line KJKJKJKK). At end, ones_cnt=1 -> DATA.
//  - DATA: pop a byte at each byte boundary and shift it out LSB first.
//  - EOP: SE0 (dp=dm=0) for 2 bit times, then J for 1 bit time. Then tx_done pulse, tx_busy=0 -> IDLE.
//  NRZI and stuffing
//  - NRZI applies to every encoded bit, stuffed bits included: 0 toggles J<->K, 1 holds.
//  - ones_cnt counts consecutive 1s. When it reaches 6, insert a 0 bit and clear ones_cnt.
//  - A stuffed bit after the final data bit is emitted before EOP.
//  Packet end
//  - Normal end: after the last bit (plus any pending stuff bit) of a byte popped with tx_last=1 -> EOP.
//  - Underrun: at a byte boundary with the FIFO empty and tx_last not yet seen:
//    tx_underrun pulse, no further data bits, -> EOP, then tx_done.
//  - If the FIFO is empty when SYNC ends, treat it as an underrun.
//  - Simultaneous push and pop on a full FIFO is legal; occupancy is unchanged.
//  - A push arriving in the same cycle as the empty-check is too late; underrun is taken.
// STRUCTURE
//  Package usb_tx_pkg holds:
//  - state_t enum {IDLE, SYNC, DATA, EOP};
//  - SYNC_PATTERN=8'h80 (as shifted LSB first = 00000001);
//  - STUFF_LIMIT=6;
//  - line_t {dp, dm} constants J_FS, K_FS, SE0.
//  Sub-module tx_byte_fifo:
//  - parametrised by FIFO_DEPTH;
//  - stores {last, data[7:0]};
//  - ports push/pop/full/empty/count.
//  Top holds bit timer, FSM, shifter, stuff counter, NRZI register.
// TESTING
//  - Full-speed byte: preload 0x6E last=1, start -> dp per bit 0101 0100 | 1111 0001 | 00 1 (dm=~dp except SE0).
//    tx_done 152 clk after start.
//  - Stuffing: preload 0xFF last=1 -> stuffed 0 after the 5th data bit; line toggles there.
//    9 data bit times; tx_done at 160 clk.
//  - Streaming: 5 bytes (FIFO_DEPTH=4) with tx_valid held -> tx_ready drops while full.
//    Bytes are sent back to back with no gap bits; single tx_done.
//  - Underrun: push 2 bytes, neither with last=1 -> tx_underrun after byte 2, then SE0 SE0 J, then tx_done.
//  - Reset mid-DATA: assert rst at byte 1 bit 3 -> next edge J, tx_busy=0, tx_ready=1, no tx_done.
//    A new packet sends correctly afterwards.
//  - LOW_SPEED=1: same 0x6E packet -> dp/dm swapped relative to the first scenario; IDLE shows dm=1.

Source files
------------

// File: rtl/usb_tx_line_encoder_pkg.sv
// Shared types and constants for the USB transmit line encoder.
//   state_t      : encoder FSM states
//   SYNC_PATTERN : SYNC byte, shifted out LSB first (00000001)
//   STUFF_LIMIT  : run of 1s after which a 0 is inserted
//   line_t       : {dp, dm} line pair, full-speed polarity
package usb_tx_pkg;

  typedef enum logic [1:0] {IDLE, SYNC, DATA, EOP} state_t;

  localparam logic [7:0]  SYNC_PATTERN = 8'h80;
  localparam int unsigned STUFF_LIMIT  = 6;

  typedef struct packed {
    logic dp;
    logic dm;
  } line_t;

  localparam line_t J_FS = 2'b10;
  localparam line_t K_FS = 2'b01;
  localparam line_t SE0  = 2'b00;

endpackage

// File: rtl/usb_tx_line_encoder_if.sv
// Stream and line signals of the USB transmit line encoder.
//   master : packet-assembly side (drives start/data/valid/last)
//   slave  : encoder side (drives ready, lines and status)
interface usb_tx_line_encoder_if;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_last;
  logic       tx_ready;
  logic       d_plus;
  logic       d_minus;
  logic       tx_busy;
  logic       tx_done;
  logic       tx_underrun;

  modport master (
    output tx_start, tx_data, tx_valid, tx_last,
    input  tx_ready, d_plus, d_minus, tx_busy, tx_done, tx_underrun
  );

  modport slave (
    input  tx_start, tx_data, tx_valid, tx_last,
    output tx_ready, d_plus, d_minus, tx_busy, tx_done, tx_underrun
  );
endinterface

// File: rtl/usb_tx_line_encoder_tx_byte_fifo.sv
// Byte FIFO for the USB transmit encoder; each entry is {last, data[7:0]}.
//   clk, rst : clock, synchronous active-high reset (flushes the FIFO)
//   push     : write wr_entry (taken when not full, or when popping)
//   pop      : discard head entry (ignored when empty)
//   rd_entry : head entry, valid while !empty
//   full, empty, count : occupancy status
module tx_byte_fifo #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  logic [8:0]                    wr_entry,
  input  logic                          pop,
  output logic [8:0]                    rd_entry,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   count
);
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [8:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full     = (count == (AW+1)'(FIFO_DEPTH));
  assign empty    = (count == '0);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign rd_entry = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_entry;
  end

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/usb_tx_line_encoder.sv
// USB transmit line encoder: buffers packet bytes and drives D+/D- with
// SYNC, NRZI bit-stuffed data (LSB first) and EOP.
//   clk, rst : clock, synchronous active-high reset
//   bus      : stream input (tx_start/tx_data/tx_valid/tx_last/tx_ready),
//              line outputs (d_plus/d_minus) and status (tx_busy/tx_done/tx_underrun)
//
//   state | meaning
//   IDLE  | lines at J, waiting for tx_start
//   SYNC  | shifting out the SYNC pattern
//   DATA  | shifting out FIFO bytes with stuffing
//   EOP   | SE0 for two bit times, then J for one
module usb_tx_line_encoder
  import usb_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 8,
  parameter int FIFO_DEPTH   = 4,
  parameter bit LOW_SPEED    = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  usb_tx_line_encoder_if.slave  bus
);
  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

  state_t     state, state_nxt;
  logic [CNT_W-1:0] bit_cnt;
  logic [7:0] shreg, shreg_nxt;
  logic [2:0] bits_left, bits_left_nxt;
  logic [2:0] ones_cnt, ones_cnt_nxt;
  logic       last_seen, last_seen_nxt;
  logic [1:0] eop_cnt, eop_cnt_nxt;
  logic       lvl, lvl_nxt;          // NRZI level, 1 = J
  logic       se0, se0_nxt;
  logic       done_r, done_nxt;
  logic       underrun_r, underrun_nxt;

  logic       start_ok;
  logic       boundary;
  logic       fifo_pop;
  logic [8:0] fifo_rd;
  logic       fifo_full;
  logic       fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] unused_fifo_count;
  line_t      line_fs;

  tx_byte_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (bus.tx_valid && bus.tx_ready),
    .wr_entry ({bus.tx_last, bus.tx_data}),
    .pop      (fifo_pop),
    .rd_entry (fifo_rd),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (unused_fifo_count)
  );

  assign start_ok = (state == IDLE) && bus.tx_start;
  assign boundary = (state != IDLE) && (bit_cnt == CNT_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shreg      <= '0;
      bits_left  <= '0;
      ones_cnt   <= '0;
      last_seen  <= 1'b0;
      eop_cnt    <= '0;
      lvl        <= 1'b1;
      se0        <= 1'b0;
      done_r     <= 1'b0;
      underrun_r <= 1'b0;
    end else begin
      state      <= state_nxt;
      shreg      <= shreg_nxt;
      bits_left  <= bits_left_nxt;
      ones_cnt   <= ones_cnt_nxt;
      last_seen  <= last_seen_nxt;
      eop_cnt    <= eop_cnt_nxt;
      lvl        <= lvl_nxt;
      se0        <= se0_nxt;
      done_r     <= done_nxt;
      underrun_r <= underrun_nxt;
      if (start_ok || boundary || state == IDLE) bit_cnt <= '0;
      else                                       bit_cnt <= bit_cnt + 1'b1;
    end
  end

  // Each branch below decides the bit that occupies the next bit time.
  always_comb begin
    state_nxt     = state;
    shreg_nxt     = shreg;
    bits_left_nxt = bits_left;
    ones_cnt_nxt  = ones_cnt;
    last_seen_nxt = last_seen;
    eop_cnt_nxt   = eop_cnt;
    lvl_nxt       = lvl;
    se0_nxt       = se0;
    done_nxt      = 1'b0;
    underrun_nxt  = 1'b0;
    fifo_pop      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.tx_start) begin
          state_nxt     = SYNC;
          shreg_nxt     = SYNC_PATTERN >> 1;
          bits_left_nxt = 3'd7;
          last_seen_nxt = 1'b0;
          se0_nxt       = 1'b0;
          lvl_nxt       = SYNC_PATTERN[0] ? lvl : ~lvl;
          ones_cnt_nxt  = SYNC_PATTERN[0] ? 3'd1 : 3'd0;
        end
      end
      SYNC, DATA: begin
        if (boundary) begin
          if (ones_cnt == 3'(STUFF_LIMIT)) begin
            // stuffed 0 takes priority, so it also lands before EOP
            lvl_nxt      = ~lvl;
            ones_cnt_nxt = 3'd0;
          end else if (bits_left != 3'd0) begin
            lvl_nxt       = shreg[0] ? lvl : ~lvl;
            ones_cnt_nxt  = shreg[0] ? ones_cnt + 3'd1 : 3'd0;
            shreg_nxt     = shreg >> 1;
            bits_left_nxt = bits_left - 3'd1;
          end else if (last_seen || fifo_empty) begin
            // empty is the registered flag, so a same-cycle push is too late
            underrun_nxt = !last_seen;
            state_nxt    = EOP;
            se0_nxt      = 1'b1;
            eop_cnt_nxt  = 2'd0;
          end else begin
            fifo_pop      = 1'b1;
            lvl_nxt       = fifo_rd[0] ? lvl : ~lvl;
            ones_cnt_nxt  = fifo_rd[0] ? ones_cnt + 3'd1 : 3'd0;
            shreg_nxt     = fifo_rd[7:0] >> 1;
            bits_left_nxt = 3'd7;
            last_seen_nxt = fifo_rd[8];
            state_nxt     = DATA;
          end
        end
      end
      EOP: begin
        if (boundary) begin
          case (eop_cnt)
            2'd0: eop_cnt_nxt = 2'd1;
            2'd1: begin
              se0_nxt     = 1'b0;
              lvl_nxt     = 1'b1;
              eop_cnt_nxt = 2'd2;
            end
            default: begin
              state_nxt = IDLE;
              done_nxt  = 1'b1;
            end
          endcase
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign line_fs = se0 ? SE0 : (lvl ? J_FS : K_FS);

  // Low speed swaps the J/K polarity; SE0 is unaffected by the swap.
  assign bus.d_plus      = LOW_SPEED ? line_fs.dm : line_fs.dp;
  assign bus.d_minus     = LOW_SPEED ? line_fs.dp : line_fs.dm;
  assign bus.tx_ready    = !fifo_full;
  assign bus.tx_busy     = (state != IDLE);
  assign bus.tx_done     = done_r;
  assign bus.tx_underrun = underrun_r;
endmodule

// File: tb/tb_usb_tx_line_encoder.sv
// Randomized bench for usb_tx_line_encoder: a full-speed and a low-speed
// instance share stimulus and are checked against a bit-list reference model.
module tb_usb_tx_line_encoder;
  localparam int CPB   = 8;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  usb_tx_line_encoder_if bus_fs();
  usb_tx_line_encoder_if bus_ls();

  assign bus_ls.tx_start = bus_fs.tx_start;
  assign bus_ls.tx_data  = bus_fs.tx_data;
  assign bus_ls.tx_valid = bus_fs.tx_valid;
  assign bus_ls.tx_last  = bus_fs.tx_last;

  usb_tx_line_encoder #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .LOW_SPEED(1'b0)) dut_fs (
    .clk(clk), .rst(rst), .bus(bus_fs));
  usb_tx_line_encoder #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .LOW_SPEED(1'b1)) dut_ls (
    .clk(clk), .rst(rst), .bus(bus_ls));

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] byte_q[$];
  logic [1:0] exp_line[$];   // full-speed {dp,dm} per bit time
  int         n_pre_eop;
  int         pushed;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Whole packet as one bit list: SYNC + data, stuffed, NRZI, then EOP.
  task automatic build_model();
    bit bits[$];
    bit st[$];
    int ones;
    bit lvl;
    exp_line.delete();
    for (int i = 0; i < 8; i++) bits.push_back(i == 7);
    foreach (byte_q[k]) for (int b = 0; b < 8; b++) bits.push_back(byte_q[k][b]);
    ones = 0;
    foreach (bits[i]) begin
      st.push_back(bits[i]);
      if (bits[i]) ones++; else ones = 0;
      if (ones == 6) begin st.push_back(1'b0); ones = 0; end
    end
    lvl = 1'b1;
    foreach (st[i]) begin
      if (!st[i]) lvl = ~lvl;
      exp_line.push_back({lvl, ~lvl});
    end
    n_pre_eop = exp_line.size();
    exp_line.push_back(2'b00);
    exp_line.push_back(2'b00);
    exp_line.push_back(2'b10);
  endtask

  function automatic logic [3:0] lines_now();
    return {bus_fs.d_plus, bus_fs.d_minus, bus_ls.d_plus, bus_ls.d_minus};
  endfunction

  task automatic run_packet(input bit has_last, input bit poke_start, output int done_at);
    int  nb, lim, und_at, n_done, n_und;
    bit  saw_full;
    build_model();
    nb = exp_line.size();
    lim = (byte_q.size() < DEPTH) ? byte_q.size() : DEPTH;
    pushed = 0; saw_full = 0; done_at = -1; und_at = -1; n_done = 0; n_und = 0;
    fork
      begin
        for (int i = 0; i < byte_q.size(); i++) begin
          int t;
          bit rdy;
          t = 0;
          bus_fs.tx_data  = byte_q[i];
          bus_fs.tx_last  = has_last && (i == byte_q.size() - 1);
          bus_fs.tx_valid = 1'b1;
          do begin
            rdy = bus_fs.tx_ready;
            if (!rdy) saw_full = 1'b1;
            @(negedge clk);
            t++;
          end while (!rdy && t < 2000);
          if (!rdy) check_eq("push_timeout", 32'd1, 32'd0);
          pushed++;
        end
        bus_fs.tx_valid = 1'b0;
        bus_fs.tx_last  = 1'b0;
      end
      begin
        int t;
        t = 0;
        while (pushed < lim && t < 100) begin @(negedge clk); t++; end
        bus_fs.tx_start = 1'b1;
        @(negedge clk);
        bus_fs.tx_start = 1'b0;
        for (int n = 0; n <= nb * CPB + 4; n++) begin
          if ((n % CPB) == CPB / 2 && (n / CPB) < nb) begin
            logic [1:0] e;
            e = exp_line[n / CPB];
            check_eq($sformatf("line_bit%0d", n / CPB), 32'(lines_now()), 32'({e, e[0], e[1]}));
            check_eq("busy", 32'(bus_fs.tx_busy), 32'd1);
          end
          if (bus_fs.tx_done) begin n_done++; if (done_at < 0) done_at = n; end
          if (bus_fs.tx_underrun) begin n_und++; if (und_at < 0) und_at = n; end
          bus_fs.tx_start = (poke_start && n == 3 * CPB + 1);
          @(negedge clk);
        end
      end
    join
    check_eq("done_at", 32'(done_at), 32'(nb * CPB));
    check_eq("done_cnt", 32'(n_done), 32'd1);
    check_eq("underrun_at", 32'(und_at), has_last ? 32'hFFFF_FFFF : 32'(n_pre_eop * CPB));
    check_eq("underrun_cnt", 32'(n_und), has_last ? 32'd0 : 32'd1);
    check_eq("busy_end", 32'(bus_fs.tx_busy), 32'd0);
    check_eq("ready_end", 32'(bus_fs.tx_ready), 32'd1);
    if (byte_q.size() > DEPTH) check_eq("ready_drop", 32'(saw_full), 32'd1);
  endtask

  task automatic push_byte(input logic [7:0] d, input logic l);
    bus_fs.tx_data  = d;
    bus_fs.tx_last  = l;
    bus_fs.tx_valid = 1'b1;
    @(negedge clk);
    bus_fs.tx_valid = 1'b0;
    bus_fs.tx_last  = 1'b0;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1);
  end

  initial begin
    int d;
    int sz;
    bit hl;
    int nd;
    bus_fs.tx_start = 1'b0;
    bus_fs.tx_data  = 8'h00;
    bus_fs.tx_valid = 1'b0;
    bus_fs.tx_last  = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("rst_lines", 32'(lines_now()), 32'b1001);
    check_eq("rst_busy", 32'(bus_fs.tx_busy), 32'd0);
    check_eq("rst_done", 32'({bus_fs.tx_done, bus_fs.tx_underrun}), 32'd0);
    check_eq("rst_ready", 32'(bus_fs.tx_ready), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    check_eq("idle_lines", 32'(lines_now()), 32'b1001);

    byte_q = '{8'h6E};
    run_packet(1'b1, 1'b0, d);
    check_eq("t_done_6e", 32'(d), 32'd152);

    byte_q = '{8'hFF};
    run_packet(1'b1, 1'b1, d);
    check_eq("t_done_ff", 32'(d), 32'd160);

    byte_q = '{8'h12, 8'hFF, 8'h7E, 8'hA5, 8'h3F};
    run_packet(1'b1, 1'b0, d);

    byte_q = '{8'hC3, 8'h0F};
    run_packet(1'b0, 1'b0, d);

    byte_q.delete();
    run_packet(1'b0, 1'b0, d);

    // reset in the middle of the first data byte, bit 3
    byte_q = '{8'hA5, 8'h3C};
    build_model();
    push_byte(8'hA5, 1'b0);
    push_byte(8'h3C, 1'b1);
    bus_fs.tx_start = 1'b1;
    @(negedge clk);
    bus_fs.tx_start = 1'b0;
    repeat (11 * CPB + 2) @(negedge clk);
    check_eq("pre_rst_line", 32'(lines_now()), 32'({exp_line[11], exp_line[11][0], exp_line[11][1]}));
    rst = 1'b1;
    @(negedge clk);
    check_eq("mid_rst_lines", 32'(lines_now()), 32'b1001);
    check_eq("mid_rst_busy", 32'(bus_fs.tx_busy), 32'd0);
    check_eq("mid_rst_ready", 32'(bus_fs.tx_ready), 32'd1);
    rst = 1'b0;
    nd = 0;
    repeat (4 * CPB) begin
      if (bus_fs.tx_done) nd++;
      @(negedge clk);
    end
    check_eq("mid_rst_nodone", 32'(nd), 32'd0);
    check_eq("mid_rst_idle", 32'(lines_now()), 32'b1001);

    for (int p = 0; p < 14; p++) begin
      sz = $urandom_range(0, DEPTH + 2);
      hl = (sz > DEPTH) ? 1'b1 : ((sz == 0) ? 1'b0 : 1'($urandom_range(0, 1)));
      byte_q.delete();
      for (int i = 0; i < sz; i++)
        byte_q.push_back(($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom));
      run_packet(hl, 1'($urandom_range(0, 1)), d);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
